mdu_issue_ctrl: RTL and testbench

//  EX-stage front end of the multiply/divide unit (mdu). Decodes the EX-stage MDU op and drives
//  the mdu command pins (D1/D2/Op/Start/We/HiLo/madd). Stalls the pipeline while mdu is Busy.

---
 rtl/mdu_issue_ctrl_pkg.sv | 71 +++++++
 rtl/mdu_issue_ctrl_if.sv | 41 ++++
 rtl/mdu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU op encodings and decode used by the EX-stage issue controller and the ID stage.
package mdu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMadd  = 4'd5,
    OpMthi  = 4'd6,
    OpMtlo  = 4'd7,
    OpMfhi  = 4'd8,
    OpMflo  = 4'd9
  } ex_op_e;

  typedef enum logic [1:0] {
    MdMultu = 2'b00,
    MdMult  = 2'b01,
    MdDivu  = 2'b10,
    MdDiv   = 2'b11
  } md_op_e;

  typedef enum logic {StIdle, StWait} state_e;

  typedef struct packed {
    logic   muldiv;
    logic   madd;
    logic   mt;
    logic   mf;
    logic   lo;
    md_op_e md_op;
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(input ex_op_e op);
    mdu_dec_t d;
    d = '0;
    case (op)
      OpMult:  begin d.muldiv = 1'b1; d.md_op = MdMult; end
      OpMultu: begin d.muldiv = 1'b1; d.md_op = MdMultu; end
      OpDiv:   begin d.muldiv = 1'b1; d.md_op = MdDiv; end
      OpDivu:  begin d.muldiv = 1'b1; d.md_op = MdDivu; end
      OpMadd:  begin d.madd = 1'b1; d.md_op = MdMult; end
      OpMthi:  d.mt = 1'b1;
      OpMtlo:  begin d.mt = 1'b1; d.lo = 1'b1; end
      OpMfhi:  d.mf = 1'b1;
      OpMflo:  begin d.mf = 1'b1; d.lo = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_muldiv(input ex_op_e op);
    mdu_dec_t d;
    d = mdu_decode(op);
    return d.muldiv;
  endfunction

  function automatic logic is_mt(input ex_op_e op);
    mdu_dec_t d;
    d = mdu_decode(op);
    return d.mt;
  endfunction

  function automatic logic is_mf(input ex_op_e op);
    mdu_dec_t d;
    d = mdu_decode(op);
    return d.mf;
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// EX-stage / mdu signal bundle; master is the issue controller, slave is the surrounding pipeline.
interface mdu_issue_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import mdu_issue_ctrl_pkg::*;

  logic             ex_valid;
  ex_op_e           ex_op;
  logic [31:0]      ex_rs;
  logic [31:0]      ex_rt;
  logic             ex_exception;
  logic             ex_flush;
  logic             md_busy;
  logic [31:0]      md_hi;
  logic [31:0]      md_lo;
  logic [31:0]      md_d1;
  logic [31:0]      md_d2;
  logic [1:0]       md_op;
  logic             md_start;
  logic             md_we;
  logic             md_hilo;
  logic             md_madd;
  logic             stall;
  logic             mf_valid;
  logic [31:0]      mf_result;
  logic [CNT_W-1:0] stall_cnt;
  logic             wait_err;

  modport master (
    input  ex_valid, ex_op, ex_rs, ex_rt, ex_exception, ex_flush, md_busy, md_hi, md_lo,
    output md_d1, md_d2, md_op, md_start, md_we, md_hilo, md_madd, stall, mf_valid, mf_result,
           stall_cnt, wait_err
  );

  modport slave (
    output ex_valid, ex_op, ex_rs, ex_rt, ex_exception, ex_flush, md_busy, md_hi, md_lo,
    input  md_d1, md_d2, md_op, md_start, md_we, md_hilo, md_madd, stall, mf_valid, mf_result,
           stall_cnt, wait_err
  );

endinterface

// File: rtl/mdu_issue_ctrl.sv
// EX-stage MDU issue controller: issues ops to the mdu same-cycle, or parks one in a hold
// buffer and stalls while the mdu is busy.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    Clk,
  input  logic                    resetn,
  mdu_issue_ctrl_if.master        mdu_io
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  ex_op_e           hold_op_q, hold_op_d;
  logic [31:0]      hold_rs_q, hold_rs_d;
  logic [31:0]      hold_rt_q, hold_rt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_err_q, wait_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        need, kill, issue_en, issue_ok, stall;
  ex_op_e      iss_op;
  logic [31:0] iss_rs, iss_rt;
  mdu_dec_t    dec;

  always_comb begin
    state_d    = state_q;
    hold_op_d  = hold_op_q;
    hold_rs_d  = hold_rs_q;
    hold_rt_d  = hold_rt_q;
    wait_cnt_d = wait_cnt_q;
    issue_en   = 1'b0;
    stall      = 1'b0;
    iss_op     = mdu_io.ex_op;
    iss_rs     = mdu_io.ex_rs;
    iss_rt     = mdu_io.ex_rt;
    need       = mdu_io.ex_valid && (mdu_io.ex_op != OpNone);
    kill       = mdu_io.ex_exception || mdu_io.ex_flush;

    unique case (state_q)
      StIdle: begin
        if (need && !kill) begin
          if (mdu_io.md_busy) begin
            stall      = 1'b1;
            hold_op_d  = mdu_io.ex_op;
            hold_rs_d  = mdu_io.ex_rs;
            hold_rt_d  = mdu_io.ex_rt;
            wait_cnt_d = '0;
            state_d    = StWait;
          end else begin
            issue_en = 1'b1;
          end
        end
      end
      StWait: begin
        iss_op = hold_op_q;
        iss_rs = hold_rs_q;
        iss_rt = hold_rt_q;
        // Flush wins even if md_busy falls in the same cycle.
        if (mdu_io.ex_flush) begin
          hold_op_d = OpNone;
          state_d   = StIdle;
        end else if (mdu_io.md_busy) begin
          stall = 1'b1;
          if (wait_cnt_q != WaitW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          issue_en  = 1'b1;
          hold_op_d = OpNone;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    wait_err_d  = wait_err_q || (wait_cnt_d == WaitW'(MAX_WAIT));
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_comb begin
    dec                = mdu_decode(iss_op);
    issue_ok           = issue_en && resetn;
    mdu_io.md_d1       = iss_rs;
    mdu_io.md_d2       = iss_rt;
    mdu_io.md_op       = dec.md_op;
    mdu_io.md_hilo     = dec.lo;
    mdu_io.md_start    = issue_ok && dec.muldiv;
    mdu_io.md_madd     = issue_ok && dec.madd;
    mdu_io.md_we       = issue_ok && dec.mt;
    mdu_io.mf_valid    = issue_ok && dec.mf;
    mdu_io.mf_result   = dec.lo ? mdu_io.md_lo : mdu_io.md_hi;
    mdu_io.stall       = stall && resetn;
    mdu_io.stall_cnt   = stall_cnt_q;
    mdu_io.wait_err    = wait_err_q;
  end

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      hold_op_q   <= OpNone;
      hold_rs_q   <= '0;
      hold_rt_q   <= '0;
      wait_cnt_q  <= '0;
      wait_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_op_q   <= hold_op_d;
      hold_rs_q   <= hold_rs_d;
      hold_rt_q   <= hold_rt_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_err_q  <= wait_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  strobe_onehot_a: assert property (@(posedge Clk) disable iff (!resetn)
    $onehot0({mdu_io.md_start, mdu_io.md_we, mdu_io.md_madd}));

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl with a behavioural mdu and an MF result scoreboard.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  localparam int unsigned MaxWait = 16;
  localparam int unsigned CntW    = 32;
  localparam int          MulLat  = 4;
  localparam int          DivLat  = 8;

  logic Clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 Clk = ~Clk;

  mdu_issue_ctrl_if #(.CNT_W(CntW)) ifc ();

  mdu_issue_ctrl #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .Clk    (Clk),
    .resetn (resetn),
    .mdu_io (ifc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Behavioural mdu
  logic        m_busy = 1'b0;
  logic        hold_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  assign ifc.md_busy = m_busy | hold_busy;
  assign ifc.md_hi   = m_hi;
  assign ifc.md_lo   = m_lo;

  function automatic logic [63:0] mdu_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00:   return {32'd0, a} * {32'd0, b};
      2'b01:   return sa * sb;
      2'b10:   return (b == 0) ? 64'd0 : {a % b, a / b};
      default: begin
        if (b == 0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
    endcase
  endfunction

  always @(posedge Clk) begin
    if (ifc.md_start) begin
      m_busy <= 1'b1;
      m_cnt  <= ifc.md_op[1] ? DivLat : MulLat;
      m_res  <= mdu_calc(ifc.md_op, ifc.md_d1, ifc.md_d2);
    end else if (ifc.md_madd) begin
      m_busy <= 1'b1;
      m_cnt  <= MulLat;
      m_res  <= {m_hi, m_lo} + mdu_calc(2'b01, ifc.md_d1, ifc.md_d2);
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy       <= 1'b0;
        {m_hi, m_lo} <= m_res;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (ifc.md_we) begin
      if (ifc.md_hilo) m_lo <= ifc.md_d1;
      else             m_hi <= ifc.md_d1;
    end
  end

  int n_start = 0;
  int n_we    = 0;
  int n_madd  = 0;
  always @(negedge Clk) begin
    if (ifc.md_start) n_start <= n_start + 1;
    if (ifc.md_we)    n_we    <= n_we + 1;
    if (ifc.md_madd)  n_madd  <= n_madd + 1;
  end

  // Drives one op from posedge+1, rides out any stall, leaves EX empty at the next posedge+1.
  task automatic issue(input ex_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] exp_mf, output int stalls, output logic [4:0] snap);
    logic [31:0] exp;
    stalls = 0;
    ifc.ex_valid = 1'b1;
    ifc.ex_op    = op;
    ifc.ex_rs    = rs;
    ifc.ex_rt    = rt;
    if (is_mf(op)) exp_q.push_back(exp_mf);
    forever begin
      @(negedge Clk);
      if (!ifc.stall) break;
      stalls++;
      if (stalls > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout op=%0d stalled %0d cycles, required release", op, stalls);
        break;
      end
      @(posedge Clk); #1;
    end
    snap = {ifc.md_start, ifc.md_we, ifc.md_madd, ifc.md_op};
    if (is_mf(op)) begin
      checks++;
      exp = exp_q.pop_front();
      if (ifc.mf_valid !== 1'b1 || ifc.mf_result !== exp) begin
        errors++;
        $display("FAIL mf_result op=%0d got valid=%b data=%h, required valid=1 data=%h",
                 op, ifc.mf_valid, ifc.mf_result, exp);
      end
    end
    @(posedge Clk); #1;
    ifc.ex_valid = 1'b0;
    ifc.ex_op    = OpNone;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!m_busy) begin done = 1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle md_busy still 1 after 100 cycles, required 0");
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifc.ex_valid = 1'b1; ifc.ex_op = OpMult; ifc.ex_rs = 32'd5; ifc.ex_rt = 32'd6;
    ifc.ex_exception = 1'b0; ifc.ex_flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    checks++;
    if (ifc.md_start !== 1'b0 || ifc.stall !== 1'b0 || ifc.mf_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got start=%b stall=%b mf_valid=%b, required 0/0/0",
               ifc.md_start, ifc.stall, ifc.mf_valid);
    end
    checks++;
    if (ifc.stall_cnt !== '0 || ifc.wait_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got stall_cnt=%0d wait_err=%b, required 0/0",
               ifc.stall_cnt, ifc.wait_err);
    end
    @(posedge Clk); #1;
    resetn = 1'b1;
    ifc.ex_valid = 1'b0; ifc.ex_op = OpNone;
    @(posedge Clk); #1;
  endtask

  task automatic test_mult_mflo();
    int st; logic [4:0] snap;
    issue(OpMult, 32'hFFFF_FFFD, 32'd7, '0, st, snap);
    checks++;
    if (st != 0 || snap[4] !== 1'b1 || snap[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL mult_issue got stalls=%0d start=%b md_op=%b, required 0/1/01",
               st, snap[4], snap[1:0]);
    end
    issue(OpMflo, '0, '0, 32'hFFFF_FFEB, st, snap);
    checks++;
    if (st != MulLat) begin
      errors++;
      $display("FAIL mflo_stall got %0d cycles, required %0d", st, MulLat);
    end
  endtask

  task automatic test_divu_mfhi();
    int st; logic [4:0] snap;
    issue(OpDivu, 32'd100, 32'd7, '0, st, snap);
    checks++;
    if (snap[4] !== 1'b1 || snap[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL divu_issue got start=%b md_op=%b, required 1/10", snap[4], snap[1:0]);
    end
    issue(OpMfhi, '0, '0, 32'd2, st, snap);
    checks++;
    if (st != DivLat) begin
      errors++;
      $display("FAIL mfhi_stall got %0d cycles, required %0d", st, DivLat);
    end
    checks++;
    if (ifc.stall_cnt !== CntW'(MulLat + DivLat)) begin
      errors++;
      $display("FAIL stall_cnt got %0d, required %0d", ifc.stall_cnt, MulLat + DivLat);
    end
  endtask

  task automatic test_exception_mt();
    int st; logic [4:0] snap;
    ifc.ex_valid = 1'b1; ifc.ex_op = OpMthi; ifc.ex_rs = 32'hDEAD; ifc.ex_exception = 1'b1;
    @(negedge Clk);
    checks++;
    if (ifc.md_we !== 1'b0 || ifc.stall !== 1'b0) begin
      errors++;
      $display("FAIL exc_mthi got we=%b stall=%b, required 0/0", ifc.md_we, ifc.stall);
    end
    @(posedge Clk); #1;
    ifc.ex_valid = 1'b0; ifc.ex_op = OpNone; ifc.ex_exception = 1'b0;
    issue(OpMfhi, '0, '0, 32'd2, st, snap);
    issue(OpMtlo, 32'h55, '0, '0, st, snap);
    checks++;
    if (snap[3] !== 1'b1 || st != 0) begin
      errors++;
      $display("FAIL mtlo_issue got we=%b stalls=%0d, required 1/0", snap[3], st);
    end
    issue(OpMflo, '0, '0, 32'h55, st, snap);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL mtlo_mflo_stall got %0d cycles, required 0", st);
    end
  endtask

  task automatic test_flush_wait();
    int st; int madd0; logic [4:0] snap;
    madd0 = n_madd;
    issue(OpDiv, 32'hFFFF_FFCE, 32'd7, '0, st, snap);
    ifc.ex_valid = 1'b1; ifc.ex_op = OpMadd; ifc.ex_rs = 32'd1000; ifc.ex_rt = 32'd1000;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b1 || ifc.md_madd !== 1'b0) begin
      errors++;
      $display("FAIL madd_park got stall=%b madd=%b, required 1/0", ifc.stall, ifc.md_madd);
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    ifc.ex_flush = 1'b1;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.md_madd !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait got stall=%b madd=%b, required 0/0", ifc.stall, ifc.md_madd);
    end
    @(posedge Clk); #1;
    ifc.ex_flush = 1'b0; ifc.ex_valid = 1'b0; ifc.ex_op = OpNone;
    wait_idle();
    issue(OpMfhi, '0, '0, 32'hFFFF_FFFF, st, snap);
    issue(OpMflo, '0, '0, 32'hFFFF_FFF9, st, snap);
    checks++;
    if (n_madd != madd0) begin
      errors++;
      $display("FAIL madd_count got %0d pulses, required 0", n_madd - madd0);
    end
  endtask

  task automatic test_wait_err();
    int st; logic [4:0] snap;
    hold_busy = 1'b1;
    ifc.ex_valid = 1'b1; ifc.ex_op = OpMultu; ifc.ex_rs = 32'd6; ifc.ex_rt = 32'd7;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b1 || ifc.md_start !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry got stall=%b start=%b, required 1/0", ifc.stall, ifc.md_start);
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      ifc.ex_rs = 32'd99;
      @(negedge Clk);
      checks++;
      if (ifc.stall !== 1'b1 || ifc.wait_err !== (k > MaxWait)) begin
        errors++;
        $display("FAIL wait_err cycle %0d got stall=%b err=%b, required 1/%b",
                 k, ifc.stall, ifc.wait_err, (k > MaxWait));
      end
    end
    @(posedge Clk); #1;
    hold_busy = 1'b0;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.md_start !== 1'b1 || ifc.md_op !== 2'b00 ||
        ifc.md_d1 !== 32'd6 || ifc.md_d2 !== 32'd7) begin
      errors++;
      $display("FAIL held_issue got stall=%b start=%b op=%b d1=%0d d2=%0d, required 0/1/00/6/7",
               ifc.stall, ifc.md_start, ifc.md_op, ifc.md_d1, ifc.md_d2);
    end
    @(posedge Clk); #1;
    ifc.ex_valid = 1'b0; ifc.ex_op = OpNone; ifc.ex_rs = '0;
    wait_idle();
    issue(OpMflo, '0, '0, 32'd42, st, snap);
    checks++;
    if (ifc.wait_err !== 1'b1) begin
      errors++;
      $display("FAIL wait_err_sticky got %b, required 1", ifc.wait_err);
    end
  endtask

  task automatic test_reset_in_wait();
    int st; int we0; logic [4:0] snap;
    we0 = n_we;
    hold_busy = 1'b1;
    ifc.ex_valid = 1'b1; ifc.ex_op = OpMtlo; ifc.ex_rs = 32'h1234;
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_wait got stall=%b, required 1", ifc.stall);
    end
    @(posedge Clk); #1;
    resetn = 1'b0; hold_busy = 1'b0; ifc.ex_valid = 1'b0; ifc.ex_op = OpNone;
    @(negedge Clk);
    checks++;
    if (ifc.md_we !== 1'b0 || ifc.stall !== 1'b0 || ifc.mf_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate got we=%b stall=%b mf_valid=%b, required 0/0/0",
               ifc.md_we, ifc.stall, ifc.mf_valid);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if (ifc.stall_cnt !== '0 || ifc.wait_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait got stall_cnt=%0d wait_err=%b, required 0/0",
               ifc.stall_cnt, ifc.wait_err);
    end
    @(posedge Clk); #1;
    resetn = 1'b1;
    @(negedge Clk);
    checks++;
    if (ifc.stall !== 1'b0 || ifc.md_we !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got stall=%b we=%b, required 0/0", ifc.stall, ifc.md_we);
    end
    @(posedge Clk); #1;
    issue(OpMflo, '0, '0, 32'd42, st, snap);
    checks++;
    if (st != 0 || n_we != we0) begin
      errors++;
      $display("FAIL reset_idle got stalls=%0d we_pulses=%0d, required 0/0", st, n_we - we0);
    end
  endtask

  initial begin
    ifc.ex_valid = 1'b0; ifc.ex_op = OpNone; ifc.ex_rs = '0; ifc.ex_rt = '0;
    ifc.ex_exception = 1'b0; ifc.ex_flush = 1'b0;
    test_reset();
    test_mult_mflo();
    test_divu_mfhi();
    test_exception_mt();
    test_flush_wait();
    test_wait_err();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
